// File: rtl/axis_pcie_tx_arb.sv
`default_nettype none
// ============================================================================
//  Module   : axis_pcie_tx_arb
//  Purpose  : Merges several AXI-S PCIe TLP sources onto one TX channel.
//             Round-robin grant at packet boundaries, grant held to eop,
//             interrupt requests metered against host-returned credits,
//             registered output stage.
//  Revision : 1.0 - initial release
// ============================================================================
module axis_pcie_tx_arb #(
  parameter int NUM_SRC             = 3,
  parameter int MAX_IRQ_OUTSTANDING = 4
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [NUM_SRC-1:0]                         src_tvalid,
  output logic [NUM_SRC-1:0]                         src_tready,
  input  logic [NUM_SRC*128-1:0]                     src_hdr,
  input  logic [NUM_SRC*256-1:0]                     src_payload,
  input  logic [NUM_SRC-1:0]                         src_sop,
  input  logic [NUM_SRC-1:0]                         src_eop,
  input  logic [NUM_SRC-1:0]                         src_afu_irq,
  input  logic [NUM_SRC*8-1:0]                       src_irq_id,
  output logic                                       tx_tvalid,
  input  logic                                       tx_tready,
  output logic [127:0]                               tx_hdr,
  output logic [255:0]                               tx_payload,
  output logic                                       tx_sop,
  output logic                                       tx_eop,
  output logic                                       tx_afu_irq,
  output logic [7:0]                                 tx_irq_id,
  input  logic                                       irq_rsp_tvalid,
  output logic [$clog2(MAX_IRQ_OUTSTANDING+1)-1:0]   irq_outstanding,
  output logic                                       err_no_sop,
  output logic                                       err_irq_underflow
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int CNT_W = $clog2(MAX_IRQ_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_IRQ_OUTSTANDING);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Arbitration state
  logic [0:0]       state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;

  // Credit counter and sticky errors
  logic [CNT_W-1:0] irq_cnt_q, irq_cnt_d;
  logic             err_no_sop_q, err_no_sop_d;
  logic             err_uf_q, err_uf_d;

  // Output register
  logic             tx_tvalid_q, tx_tvalid_d;
  logic [127:0]     tx_hdr_q, tx_hdr_d;
  logic [255:0]     tx_payload_q, tx_payload_d;
  logic             tx_sop_q, tx_sop_d;
  logic             tx_eop_q, tx_eop_d;
  logic             tx_afu_irq_q, tx_afu_irq_d;
  logic [7:0]       tx_irq_id_q, tx_irq_id_d;

  // Combinational arbitration signals
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] orphan;
  logic               irq_cnt_full;
  logic               win_found;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W:0]     cand;
  logic               grant_vld;
  logic [IDX_W-1:0]   grant_idx;
  logic               drop_vld;
  logic [IDX_W-1:0]   drop_idx;
  logic               out_ready;
  logic               fwd_accept;
  logic               irq_inc;

  assign irq_cnt_full = (irq_cnt_q == CNT_MAX);
  assign out_ready    = !tx_tvalid_q || tx_tready;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // A sop beat may start a packet unless it is an interrupt with no credit left
    assign eligible[g]   = src_tvalid[g] && src_sop[g] && !(src_afu_irq[g] && irq_cnt_full);
    assign orphan[g]     = src_tvalid[g] && !src_sop[g];
    // Ready is held low while reset is asserted so no beat is taken during reset
    assign src_tready[g] = !reset &&
                           ((grant_vld && (grant_idx == IDX_W'(g)) && out_ready) ||
                            (drop_vld  && (drop_idx  == IDX_W'(g))));
  end

  // Round-robin search for the first eligible source at or after rr_ptr
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
      if (cand >= (IDX_W+1)'(NUM_SRC)) begin
        cand = cand - (IDX_W+1)'(NUM_SRC);
      end
      if (!win_found && eligible[cand[IDX_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDX_W-1:0];
      end
    end
  end

  // Grant selection: owner while locked, RR winner when idle, else drop the lowest orphan beat
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = owner_q;
    drop_vld  = 1'b0;
    drop_idx  = '0;
    if (state_q == ST_LOCKED) begin
      grant_vld = 1'b1;
    end else if (win_found) begin
      grant_vld = 1'b1;
      grant_idx = win_idx;
    end else begin
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
        if (orphan[i]) begin
          drop_vld = 1'b1;
          drop_idx = IDX_W'(i);
        end
      end
    end
  end

  assign fwd_accept = grant_vld && out_ready && src_tvalid[grant_idx];
  assign irq_inc    = fwd_accept && (state_q == ST_IDLE) && src_afu_irq[grant_idx];

  // Packet-lock FSM and round-robin pointer advance
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    if (fwd_accept) begin
      if (state_q == ST_IDLE) begin
        rr_ptr_d = (32'(grant_idx) == NUM_SRC - 1) ? '0 : grant_idx + 1'b1;
      end
      if (src_eop[grant_idx]) begin
        state_d = ST_IDLE;
      end else begin
        state_d = ST_LOCKED;
        owner_d = grant_idx;
      end
    end
  end

  // Interrupt credit tracking; a simultaneous issue and response cancel out
  always_comb begin
    irq_cnt_d    = irq_cnt_q;
    err_uf_d     = err_uf_q;
    err_no_sop_d = err_no_sop_q | drop_vld;
    if (irq_inc && !irq_rsp_tvalid) begin
      irq_cnt_d = irq_cnt_q + 1'b1;
    end else if (!irq_inc && irq_rsp_tvalid) begin
      if (irq_cnt_q == '0) begin
        err_uf_d = 1'b1;
      end else begin
        irq_cnt_d = irq_cnt_q - 1'b1;
      end
    end
  end

  // Output register: load on an accepted beat, otherwise drain on tx_tready
  always_comb begin
    tx_tvalid_d  = tx_tvalid_q;
    tx_hdr_d     = tx_hdr_q;
    tx_payload_d = tx_payload_q;
    tx_sop_d     = tx_sop_q;
    tx_eop_d     = tx_eop_q;
    tx_afu_irq_d = tx_afu_irq_q;
    tx_irq_id_d  = tx_irq_id_q;
    if (fwd_accept) begin
      tx_tvalid_d  = 1'b1;
      tx_hdr_d     = src_hdr[32'(grant_idx)*128 +: 128];
      tx_payload_d = src_payload[32'(grant_idx)*256 +: 256];
      tx_sop_d     = src_sop[grant_idx];
      tx_eop_d     = src_eop[grant_idx];
      tx_afu_irq_d = src_afu_irq[grant_idx];
      tx_irq_id_d  = src_irq_id[32'(grant_idx)*8 +: 8];
    end else if (tx_tready) begin
      tx_tvalid_d  = 1'b0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= '0;
      rr_ptr_q     <= '0;
      irq_cnt_q    <= '0;
      err_no_sop_q <= 1'b0;
      err_uf_q     <= 1'b0;
      tx_tvalid_q  <= 1'b0;
      tx_hdr_q     <= '0;
      tx_payload_q <= '0;
      tx_sop_q     <= 1'b0;
      tx_eop_q     <= 1'b0;
      tx_afu_irq_q <= 1'b0;
      tx_irq_id_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      rr_ptr_q     <= rr_ptr_d;
      irq_cnt_q    <= irq_cnt_d;
      err_no_sop_q <= err_no_sop_d;
      err_uf_q     <= err_uf_d;
      tx_tvalid_q  <= tx_tvalid_d;
      tx_hdr_q     <= tx_hdr_d;
      tx_payload_q <= tx_payload_d;
      tx_sop_q     <= tx_sop_d;
      tx_eop_q     <= tx_eop_d;
      tx_afu_irq_q <= tx_afu_irq_d;
      tx_irq_id_q  <= tx_irq_id_d;
    end
  end

  assign tx_tvalid         = tx_tvalid_q;
  assign tx_hdr            = tx_hdr_q;
  assign tx_payload        = tx_payload_q;
  assign tx_sop            = tx_sop_q;
  assign tx_eop            = tx_eop_q;
  assign tx_afu_irq        = tx_afu_irq_q;
  assign tx_irq_id         = tx_irq_id_q;
  assign irq_outstanding   = irq_cnt_q;
  assign err_no_sop        = err_no_sop_q;
  assign err_irq_underflow = err_uf_q;

endmodule
`default_nettype wire
